// File: rtl/qsn_shift_sched_85b.sv
// qsn_shift_sched_85b
// Sequencer for the 85-bit quasi-cyclic shift network. Holds a table of
// per-circulant shift factors, walks a contiguous table segment on start and
// issues registered left/right/merge select words one circulant per cycle,
// with valid/last tags delayed to line up with the QSN registered output.
//
// Optional feature macro: SHIFT_RANGE_CHECK_EN
//   defined   : issued factors above 84 are replaced by 0 and err_shift is set
//               (sticky until reset or the next accepted start)
//   undefined : no check, err_shift tied to 0
//
// Ports:
//   sys_clk, rstn          clock, asynchronous active-low reset
//   cfg_we/addr/shift      shift-factor table write port
//   start/base/len         begin a layer sequence (len 0 is legal)
//   stall                  hold issue this cycle
//   busy                   sequence in progress (RUN or DRAIN)
//   left/right/merge_sel   registered QSN select words
//   issue_valid            select words valid this cycle
//   qsn_out_valid/last     issue tags delayed by QSN_LAT
//   done                   one-cycle pulse after the last qsn_out_valid
//   err_shift              sticky illegal-shift flag
module qsn_shift_sched_85b #(
  parameter int unsigned TBL_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned QSN_LAT   = 1
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [6:0]        cfg_shift,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [ADDR_W:0]   start_len,
  input  logic              stall,
  output logic              busy,
  output logic [6:0]        left_sel,
  output logic [6:0]        right_sel,
  output logic [83:0]       merge_sel,
  output logic              issue_valid,
  output logic              qsn_out_valid,
  output logic              qsn_out_last,
  output logic              done,
  output logic              err_shift
);

  localparam int unsigned DCNT_W = $clog2(QSN_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [6:0]          left_q, left_d;
  logic [6:0]          right_q, right_d;
  logic [83:0]         merge_q, merge_d;
  logic                iv_q, iv_d;
  logic                ilast_q, ilast_d;
  logic [QSN_LAT-1:0]  ov_q;
  logic [QSN_LAT-1:0]  ol_q;

  logic [6:0]          tbl_q [TBL_DEPTH];
  logic [6:0]          s_raw;
  logic [6:0]          s_eff;
  logic [6:0]          right_c;
  logic [83:0]         merge_c;

`ifdef SHIFT_RANGE_CHECK_EN
  logic                err_q, err_d;
`endif

  // Table is not reset; a same-cycle read returns the pre-write value.
  always_ff @(posedge sys_clk) begin
    if (cfg_we) tbl_q[cfg_addr] <= cfg_shift;
  end

  assign s_raw = tbl_q[rd_ptr_q];

  always_comb begin
`ifdef SHIFT_RANGE_CHECK_EN
    s_eff = (s_raw > 7'd84) ? '0 : s_raw;
`else
    s_eff = s_raw;
`endif
    right_c = (s_eff == '0) ? '0 : 7'd85 - s_eff;
    merge_c = '0;
    // Bit k set iff k < 85-s; factors above 84 leave every bit clear.
    for (int unsigned k = 0; k < 84; k++) begin
      merge_c[k] = ((k + 32'(s_eff)) < 32'd85);
    end
  end

  always_comb begin
    state_d = state_q;
    rd_ptr_d = rd_ptr_q;
    rem_d = rem_q;
    dcnt_d = dcnt_q;
    left_d = left_q;
    right_d = right_q;
    merge_d = merge_q;
    iv_d = 1'b0;
    ilast_d = 1'b0;
`ifdef SHIFT_RANGE_CHECK_EN
    err_d = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d = start_base;
          rem_d = start_len;
`ifdef SHIFT_RANGE_CHECK_EN
          err_d = 1'b0;
`endif
          if (start_len == '0) begin
            state_d = S_DRAIN;
            dcnt_d = DCNT_W'(QSN_LAT);
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          iv_d = 1'b1;
          left_d = s_eff;
          right_d = right_c;
          merge_d = merge_c;
          rd_ptr_d = (rd_ptr_q == ADDR_W'(TBL_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
`ifdef SHIFT_RANGE_CHECK_EN
          if (s_raw > 7'd84) err_d = 1'b1;
`endif
          if (rem_q == (ADDR_W + 1)'(1)) begin
            ilast_d = 1'b1;
            state_d = S_DRAIN;
            // One extra cycle covers the select register ahead of the QSN.
            dcnt_d = DCNT_W'(QSN_LAT + 1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) state_d = S_IDLE;
        else dcnt_d = dcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rd_ptr_q <= '0;
      rem_q <= '0;
      dcnt_q <= '0;
      left_q <= '0;
      right_q <= '0;
      merge_q <= '0;
      iv_q <= 1'b0;
      ilast_q <= 1'b0;
      ov_q <= '0;
      ol_q <= '0;
`ifdef SHIFT_RANGE_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q <= rem_d;
      dcnt_q <= dcnt_d;
      left_q <= left_d;
      right_q <= right_d;
      merge_q <= merge_d;
      iv_q <= iv_d;
      ilast_q <= ilast_d;
      ov_q[0] <= iv_q;
      ol_q[0] <= ilast_q;
      for (int unsigned i = 1; i < QSN_LAT; i++) begin
        ov_q[i] <= ov_q[i-1];
        ol_q[i] <= ol_q[i-1];
      end
`ifdef SHIFT_RANGE_CHECK_EN
      err_q <= err_d;
`endif
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DRAIN) && (dcnt_q == '0);
  assign left_sel      = left_q;
  assign right_sel     = right_q;
  assign merge_sel     = merge_q;
  assign issue_valid   = iv_q;
  assign qsn_out_valid = ov_q[QSN_LAT-1];
  assign qsn_out_last  = ol_q[QSN_LAT-1];
`ifdef SHIFT_RANGE_CHECK_EN
  assign err_shift     = err_q;
`else
  assign err_shift     = 1'b0;
`endif

endmodule

// File: tb/tb_qsn_shift_sched_85b.sv
// Testbench for qsn_shift_sched_85b: randomized sequences checked against a
// schedule-level reference model (issue cycles derived from the stall
// pattern, selects computed arithmetically from the shift factor).
module tb_qsn_shift_sched_85b;

  localparam int unsigned TBL_DEPTH = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned QSN_LAT   = 1;
  localparam int          MAXC      = 1024;

  logic              sys_clk;
  logic              rstn;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [6:0]        cfg_shift;
  logic              start;
  logic [ADDR_W-1:0] start_base;
  logic [ADDR_W:0]   start_len;
  logic              stall;
  logic              busy;
  logic [6:0]        left_sel;
  logic [6:0]        right_sel;
  logic [83:0]       merge_sel;
  logic              issue_valid;
  logic              qsn_out_valid;
  logic              qsn_out_last;
  logic              done;
  logic              err_shift;

  qsn_shift_sched_85b #(
    .TBL_DEPTH(TBL_DEPTH),
    .ADDR_W   (ADDR_W),
    .QSN_LAT  (QSN_LAT)
  ) dut (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_shift    (cfg_shift),
    .start        (start),
    .start_base   (start_base),
    .start_len    (start_len),
    .stall        (stall),
    .busy         (busy),
    .left_sel     (left_sel),
    .right_sel    (right_sel),
    .merge_sel    (merge_sel),
    .issue_valid  (issue_valid),
    .qsn_out_valid(qsn_out_valid),
    .qsn_out_last (qsn_out_last),
    .done         (done),
    .err_shift    (err_shift)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned checks;
  int unsigned errors;
  int          seq_id;

  task automatic check_val(input string tag, input logic [83:0] got, input logic [83:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [6:0]  m_tbl [TBL_DEPTH];
  logic [6:0]  h_left, h_right;
  logic [83:0] h_merge;
  bit          h_err;

  // Per-sequence stimulus and expectations
  bit              st_stall [MAXC];
  bit              st_we    [MAXC];
  bit              st_start [MAXC];
  logic [ADDR_W-1:0] st_waddr [MAXC];
  logic [6:0]      st_wdata [MAXC];
  logic [ADDR_W-1:0] st_base [MAXC];
  logic [ADDR_W:0] st_len   [MAXC];
  bit              iss      [MAXC];
  logic [6:0]      iss_val  [MAXC];
  bit              e_busy [MAXC], e_done [MAXC], e_iv [MAXC], e_ov [MAXC], e_last [MAXC], e_err [MAXC];
  logic [6:0]      e_left [MAXC], e_right [MAXC];
  logic [83:0]     e_merge [MAXC];

  function automatic logic [6:0] rand_shift(input bit allow_bad);
    if (allow_bad && $urandom_range(9) == 0) return 7'($urandom_range(127, 85));
    return 7'($urandom_range(84));
  endfunction

  function automatic void sel_of(input logic [6:0] s_in, output logic [6:0] l,
                                 output logic [6:0] rt, output logic [83:0] m, output bit bad);
    int s;
    logic [84:0] one85;
    logic [84:0] full;
    s = int'(s_in);
    bad = 1'b0;
`ifdef SHIFT_RANGE_CHECK_EN
    if (s > 84) begin
      bad = 1'b1;
      s = 0;
    end
`endif
    l = 7'(s);
    rt = (s == 0) ? 7'd0 : 7'((((85 - s) % 128) + 128) % 128);
    if (s > 84) begin
      m = '0;
    end else begin
      one85 = 85'd1;
      full = (one85 << (85 - s)) - one85;
      m = full[83:0];
    end
  endfunction

  task automatic write_tbl(input int a, input logic [6:0] v);
    cfg_we = 1'b1;
    cfg_addr = ADDR_W'(a);
    cfg_shift = v;
    @(posedge sys_clk); #1;
    cfg_we = 1'b0;
    m_tbl[a] = v;
  endtask

  task automatic run_seq(input int base, input int len, input int stall_pct, input int wr_pct,
                         input bit use_mask, input logic [31:0] mask, input bit rnd_start,
                         input bit allow_bad);
    int k, last_r, done_r, end_r;
    logic [6:0] cl, cr;
    logic [83:0] cm;
    bit ce, bad;
    seq_id++;
    for (int r = 0; r < MAXC; r++) begin
      if (use_mask) st_stall[r] = (r < 32) ? mask[r] : 1'b0;
      else st_stall[r] = (r > 0 && r < 600) ? ($urandom_range(99) < stall_pct) : 1'b0;
      st_we[r] = ($urandom_range(99) < wr_pct);
      st_waddr[r] = ADDR_W'($urandom_range(TBL_DEPTH - 1));
      st_wdata[r] = rand_shift(allow_bad);
      st_start[r] = (r == 0) ? 1'b1 : (rnd_start && $urandom_range(99) < 5);
      st_base[r] = (r == 0) ? ADDR_W'(base) : ADDR_W'($urandom_range(TBL_DEPTH - 1));
      st_len[r] = (r == 0) ? (ADDR_W + 1)'(len) : (ADDR_W + 1)'($urandom_range(127));
      iss[r] = 1'b0;
    end
    // Issue schedule: one entry per unstalled cycle from the cycle after start.
    k = 0;
    last_r = 0;
    for (int r = 1; k < len; r++) begin
      if (!st_stall[r]) begin
        k++;
        last_r = r;
      end
    end
    done_r = (len == 0) ? QSN_LAT + 1 : last_r + QSN_LAT + 2;
    end_r = done_r + 2;
    for (int r = done_r + 1; r < MAXC; r++) st_start[r] = 1'b0;
    // Entry values seen at each issue cycle, with writes landing after the read.
    k = 0;
    for (int r = 0; r <= end_r; r++) begin
      if (r >= 1 && k < len && !st_stall[r]) begin
        iss[r] = 1'b1;
        iss_val[r] = m_tbl[(base + k) % TBL_DEPTH];
        k++;
      end
      if (st_we[r]) m_tbl[st_waddr[r]] = st_wdata[r];
    end
    cl = h_left; cr = h_right; cm = h_merge; ce = h_err;
    for (int r = 0; r <= end_r; r++) begin
      if (r == 1) ce = 1'b0;
      e_busy[r] = (r >= 1) && (r <= done_r);
      e_done[r] = (r == done_r);
      e_iv[r] = (r >= 1) && iss[r-1];
      if (e_iv[r]) begin
        sel_of(iss_val[r-1], cl, cr, cm, bad);
        if (bad) ce = 1'b1;
      end
      e_ov[r] = (r >= 1 + int'(QSN_LAT)) && iss[r-1-QSN_LAT];
      e_last[r] = e_ov[r] && (len > 0) && ((r - 1 - int'(QSN_LAT)) == last_r);
      e_left[r] = cl; e_right[r] = cr; e_merge[r] = cm; e_err[r] = ce;
    end
    h_left = cl; h_right = cr; h_merge = cm; h_err = ce;
    for (int r = 0; r <= end_r; r++) begin
      check_val($sformatf("s%0d.r%0d.busy", seq_id, r), busy, e_busy[r]);
      check_val($sformatf("s%0d.r%0d.done", seq_id, r), done, e_done[r]);
      check_val($sformatf("s%0d.r%0d.issue_valid", seq_id, r), issue_valid, e_iv[r]);
      check_val($sformatf("s%0d.r%0d.out_valid", seq_id, r), qsn_out_valid, e_ov[r]);
      check_val($sformatf("s%0d.r%0d.out_last", seq_id, r), qsn_out_last, e_last[r]);
      check_val($sformatf("s%0d.r%0d.left", seq_id, r), left_sel, e_left[r]);
      check_val($sformatf("s%0d.r%0d.right", seq_id, r), right_sel, e_right[r]);
      check_val($sformatf("s%0d.r%0d.merge", seq_id, r), merge_sel, e_merge[r]);
      check_val($sformatf("s%0d.r%0d.err", seq_id, r), err_shift, e_err[r]);
      start = st_start[r];
      start_base = st_base[r];
      start_len = st_len[r];
      stall = st_stall[r];
      cfg_we = st_we[r];
      cfg_addr = st_waddr[r];
      cfg_shift = st_wdata[r];
      @(posedge sys_clk); #1;
    end
    start = 1'b0;
    stall = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, ".busy"}, busy, 1'b0);
    check_val({pfx, ".done"}, done, 1'b0);
    check_val({pfx, ".issue_valid"}, issue_valid, 1'b0);
    check_val({pfx, ".out_valid"}, qsn_out_valid, 1'b0);
    check_val({pfx, ".out_last"}, qsn_out_last, 1'b0);
    check_val({pfx, ".left"}, left_sel, 7'd0);
    check_val({pfx, ".right"}, right_sel, 7'd0);
    check_val({pfx, ".merge"}, merge_sel, 84'd0);
    check_val({pfx, ".err"}, err_shift, 1'b0);
  endtask

  task automatic reset_mid_run();
    for (int i = 0; i < 5; i++) write_tbl(10 + i, rand_shift(1'b0));
    start = 1'b1; start_base = ADDR_W'(10); start_len = (ADDR_W + 1)'(5); stall = 1'b0;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(posedge sys_clk); #1;
    check_val("rmr.iv1", issue_valid, 1'b1);
    @(posedge sys_clk); #1;
    check_val("rmr.iv2", issue_valid, 1'b1);
    #2 rstn = 1'b0;
    #1 check_all_zero("rmr.async");
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    @(posedge sys_clk); #1;
    check_val("rmr.idle_busy", busy, 1'b0);
    check_val("rmr.idle_done", done, 1'b0);
    h_left = '0; h_right = '0; h_merge = '0; h_err = 1'b0;
    run_seq(10, 5, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; seq_id = 0;
    rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_shift = '0;
    start = 1'b0; start_base = '0; start_len = '0; stall = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge sys_clk); #1;
    h_left = '0; h_right = '0; h_merge = '0; h_err = 1'b0;
    for (int a = 0; a < int'(TBL_DEPTH); a++) write_tbl(a, rand_shift(1'b0));

    write_tbl(0, 7'd0); write_tbl(1, 7'd1); write_tbl(2, 7'd84);
    run_seq(0, 3, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_seq(0, 3, 0, 0, 1'b1, 32'h4, 1'b0, 1'b0);

    write_tbl(62, 7'd10); write_tbl(63, 7'd20); write_tbl(0, 7'd30); write_tbl(1, 7'd40);
    run_seq(62, 4, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

    run_seq(17, 0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

    reset_mid_run();

    write_tbl(5, 7'd100);
    run_seq(5, 1, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_seq(0, 2, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int b, l;
      b = int'($urandom_range(TBL_DEPTH - 1));
      l = ($urandom_range(3) == 0) ? int'($urandom_range(127)) : int'($urandom_range(8));
      run_seq(b, l, 25, 20, 1'b0, 32'h0, 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
